// File: rtl/playfield_ram_arbiter.sv
// Arbiter for the single-port playfield RAM. The video fetch engine has priority,
// and a starvation counter forces a CPU grant so each CPU access finishes within one bus cycle.
module playfield_ram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ready,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_strobe,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VID,
        GNT_CPU
    } grant_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU_RD,
        OWN_CPU_WR
    } owner_t;

    logic              pend_q,      pend_d;
    logic              p_we_q,      p_we_d;
    logic [ADDR_W-1:0] p_addr_q,    p_addr_d;
    logic [DATA_W-1:0] p_wdata_q,   p_wdata_d;
    logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    owner_t            st1_q,       st1_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              cpu_done_q,  cpu_done_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_err_q,   cpu_err_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic   force_cpu;
    grant_t grant;

    // Only registered state feeds force_cpu, so vid_ready never depends on vid_req.
    assign force_cpu = pend_q && (wait_cnt_q == CNT_W'(STARVE_MAX));
    assign vid_ready = ~force_cpu & ~reset;

    always_comb begin
        grant = GNT_NONE;
        if (reset) begin
            grant = GNT_NONE;
        end else if (force_cpu) begin
            grant = GNT_CPU;
        end else if (vid_req) begin
            grant = GNT_VID;
        end else if (pend_q) begin
            grant = GNT_CPU;
        end
    end

    // RAM port is driven in the issue cycle itself; idle cycles replay the last address/data.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        st1_d     = OWN_NONE;
        case (grant)
            GNT_VID: begin
                ram_addr = vid_addr;
                st1_d    = OWN_VID;
            end
            GNT_CPU: begin
                ram_addr  = p_addr_q;
                ram_wdata = p_wdata_q;
                ram_we    = p_we_q;
                st1_d     = p_we_q ? OWN_CPU_WR : OWN_CPU_RD;
            end
            default: ;
        endcase
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
    end

    always_comb begin
        pend_d     = pend_q;
        p_we_d     = p_we_q;
        p_addr_d   = p_addr_q;
        p_wdata_d  = p_wdata_q;
        wait_cnt_d = wait_cnt_q;
        cpu_err_d  = cpu_err_q;
        if (cpu_strobe) begin
            // A new strobe always wins, even over an access issued this same cycle.
            pend_d     = 1'b1;
            p_we_d     = cpu_we;
            p_addr_d   = cpu_addr;
            p_wdata_d  = cpu_wdata;
            wait_cnt_d = '0;
            cpu_err_d  = cpu_err_q | pend_q;
        end else begin
            if (grant == GNT_CPU) begin
                pend_d = 1'b0;
            end
            if (pend_q && (grant != GNT_CPU) && (wait_cnt_q < CNT_W'(STARVE_MAX))) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        vid_valid_d = 1'b0;
        vid_rdata_d = vid_rdata_q;
        cpu_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        case (st1_q)
            OWN_VID: begin
                vid_valid_d = 1'b1;
                vid_rdata_d = ram_rdata;
            end
            OWN_CPU_RD: begin
                cpu_done_d  = 1'b1;
                cpu_rdata_d = ram_rdata;
            end
            OWN_CPU_WR: begin
                cpu_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= 1'b0;
            p_we_q      <= 1'b0;
            p_addr_q    <= '0;
            p_wdata_q   <= '0;
            wait_cnt_q  <= '0;
            st1_q       <= OWN_NONE;
            vid_valid_q <= 1'b0;
            vid_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            pend_q      <= pend_d;
            p_we_q      <= p_we_d;
            p_addr_q    <= p_addr_d;
            p_wdata_q   <= p_wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            st1_q       <= st1_d;
            vid_valid_q <= vid_valid_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign vid_valid = vid_valid_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;

endmodule

// File: tb/tb_playfield_ram_arbiter.sv
// Directed bench for playfield_ram_arbiter with a write-first RAM model and
// scoreboards for video reads and CPU completions.
module tb_playfield_ram_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned SM = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ready;
    logic          vid_valid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_strobe;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    playfield_ram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(SM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ready (vid_ready),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .cpu_strobe(cpu_strobe),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [DW-1:0] bg(input int unsigned a);
        return 8'((a * 37) + 11);
    endfunction

    // Write-first single-port RAM; unwritten locations read a fixed background pattern.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic          written [0:(1<<AW)-1];

    function automatic logic [DW-1:0] ram_peek(input logic [AW-1:0] a);
        return (written[a] === 1'b1) ? mem[a] : bg(int'(a));
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
            ram_rdata         <= ram_wdata;
        end else begin
            ram_rdata <= ram_peek(ram_addr);
        end
    end

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int vid_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int unsigned   at;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t vid_q[$];
    exp_t cpu_q[$];
    exp_t ev, ec, tv;

    always @(negedge clk) begin
        if (vid_valid) begin
            vid_cnt++;
            chk("vid_valid_expected", vid_q.size() > 0, 1);
            if (vid_q.size() > 0) begin
                ev = vid_q.pop_front();
                chk("vid_valid_cycle", cyc, ev.at);
                chk("vid_rdata", vid_rdata, ev.data);
            end
        end
        if (cpu_done) begin
            chk("cpu_done_expected", cpu_q.size() > 0, 1);
            if (cpu_q.size() > 0) begin
                ec = cpu_q.pop_front();
                chk("cpu_done_cycle", cyc, ec.at);
                if (ec.rd) chk("cpu_rdata", cpu_rdata, ec.data);
            end
        end
        if (vid_req && vid_ready && !reset) begin
            tv.at   = cyc + 2;
            tv.rd   = 1'b1;
            tv.data = ref_mem[vid_addr];
            vid_q.push_back(tv);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        cpu_strobe = 1'b0;
    endtask

    task automatic push_cpu(input int unsigned at, input logic rd, input logic [DW-1:0] d);
        exp_t t;
        t.at = at; t.rd = rd; t.data = d;
        cpu_q.push_back(t);
    endtask

    task automatic strobe(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_strobe = 1'b1;
        cpu_we     = we;
        cpu_addr   = a;
        cpu_wdata  = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vid_valid"}, vid_valid, 0);
        chk({tag, "_vid_rdata"}, vid_rdata, 0);
        chk({tag, "_cpu_done"},  cpu_done,  0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_cpu_err"},   cpu_err,   0);
        chk({tag, "_ram_we"},    ram_we,    0);
        chk({tag, "_ram_addr"},  ram_addr,  0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    int unsigned s;
    int unsigned vbase;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = bg(i);
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_strobe = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vid_ready", vid_ready, 0);
        chk_reset_outputs("rst");

        nxt(); reset = 1'b0;
        nxt(); nxt();

        // CPU write then read on an idle arbiter
        nxt(); s = cyc;
        strobe(1'b1, 10'h123, 8'h5A);
        push_cpu(s + 3, 1'b0, '0);
        ref_mem[10'h123] = 8'h5A;
        @(negedge clk); chk("t1_we_at_S", ram_we, 0);
        nxt(); @(negedge clk);
        chk("t1_we_at_S1", ram_we, 1);
        chk("t1_addr_at_S1", ram_addr, 10'h123);
        chk("t1_wdata_at_S1", ram_wdata, 8'h5A);
        nxt(); @(negedge clk); chk("t1_we_at_S2", ram_we, 0);
        nxt(); nxt();
        nxt(); strobe(1'b0, 10'h123, 8'h00);
        push_cpu(s + 8, 1'b1, ref_mem[10'h123]);
        repeat (5) nxt();
        @(negedge clk); chk("t1_rdata_held", cpu_rdata, 8'h5A);

        // Video stream 0..15, no CPU traffic
        vbase = vid_cnt;
        for (int i = 0; i < 16; i++) begin
            nxt(); vid_req = 1'b1; vid_addr = AW'(i);
            @(negedge clk); chk("t2_vid_ready", vid_ready, 1);
        end
        nxt(); vid_req = 1'b0;
        repeat (4) nxt();
        chk("t2_vid_count", vid_cnt - vbase, 16);

        // Continuous video with one CPU read: forced grant after STARVE_MAX
        s = 0;
        for (int k = 0; k < 20; k++) begin
            nxt(); vid_req = 1'b1; vid_addr = AW'(100 + k);
            if (k == 2) begin
                s = cyc;
                strobe(1'b0, 10'h040, 8'h00);
                push_cpu(s + 11, 1'b1, ref_mem[10'h040]);
            end
            @(negedge clk);
            chk("t3_vid_ready", vid_ready, !(k >= 2 && cyc == s + 9));
        end
        nxt(); vid_req = 1'b0;
        repeat (4) nxt();

        // Strobe coinciding with a single video request
        nxt(); s = cyc;
        vid_req = 1'b1; vid_addr = 10'h055;
        strobe(1'b0, 10'h200, 8'h00);
        push_cpu(s + 3, 1'b1, ref_mem[10'h200]);
        @(negedge clk);
        chk("t4_addr_vid", ram_addr, 10'h055);
        chk("t4_we_vid", ram_we, 0);
        nxt(); vid_req = 1'b0;
        @(negedge clk); chk("t4_addr_cpu", ram_addr, 10'h200);
        repeat (4) nxt();

        // Overlapping strobes under video load: error flag, only the second completes
        s = 0;
        for (int k = 0; k < 20; k++) begin
            nxt(); vid_req = 1'b1; vid_addr = AW'(10'h180 + k);
            if (k == 1) begin
                s = cyc;
                strobe(1'b1, 10'h300, 8'h11);
            end
            if (k == 2) begin
                strobe(1'b0, 10'h301, 8'h00);
                push_cpu(s + 12, 1'b1, ref_mem[10'h301]);
            end
            @(negedge clk);
            if (k == 2) chk("t5_err_before", cpu_err, 0);
            if (k == 3 || k == 19) chk("t5_err_sticky", cpu_err, 1);
            chk("t5_vid_ready", vid_ready, !(k >= 1 && cyc == s + 10));
        end
        nxt(); vid_req = 1'b0;
        repeat (4) nxt();
        chk("t5_first_write_dropped", ram_peek(10'h300), ref_mem[10'h300]);
        chk("t5_err_held", cpu_err, 1);

        // Reset during an in-flight CPU read
        nxt(); s = cyc;
        strobe(1'b0, 10'h010, 8'h00);
        nxt();
        nxt(); reset = 1'b1;
        @(negedge clk); chk("t6_vid_ready_in_reset", vid_ready, 0);
        nxt(); reset = 1'b0;
        @(negedge clk); chk_reset_outputs("t6");
        repeat (3) nxt();
        nxt(); s = cyc;
        strobe(1'b1, 10'h3FF, 8'hC3);
        push_cpu(s + 3, 1'b0, '0);
        ref_mem[10'h3FF] = 8'hC3;
        repeat (4) nxt();
        strobe(1'b0, 10'h3FF, 8'h00);
        push_cpu(s + 7, 1'b1, ref_mem[10'h3FF]);
        repeat (6) nxt();

        @(negedge clk);
        chk("end_vid_q_empty", vid_q.size(), 0);
        chk("end_cpu_q_empty", cpu_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/playfield_ram_arbiter.md
# playfield_ram_arbiter

Arbitrates the single-port playfield RAM between the video fetch engine in the graphics pipeline and the 6502 CPU. The video engine issues a burst of tile reads every scanline. The CPU issues at most one read or write per 1.5 MHz bus cycle, decoded by the address decoder's PF/PFRAMRD strobes. Runs entirely in the 50 MHz domain. Video has priority; a starvation guard bounds CPU latency so every CPU access completes well inside one CPU cycle (33 clk).

## Interface
- ADDR_W, 10: playfield RAM address width (1 KB).
- DATA_W, 8: data width.
- STARVE_MAX, 8: pending-CPU cycles tolerated before a forced CPU grant. Legal range 1..28.

- clk  in  1  50 MHz clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video read request; its address is on vid_addr.
- vid_addr  in  ADDR_W  video read address.
- vid_ready  out  1  video request accepted this cycle when vid_req && vid_ready.
- vid_valid  out  1  one-cycle pulse; vid_rdata holds read data.
- vid_rdata  out  DATA_W  registered video read data.
- cpu_strobe  in  1  one-cycle pulse; latches cpu_we/cpu_addr/cpu_wdata.
- cpu_we  in  1  1 = write, 0 = read (active-high, already inverted from the CPU's WE line).
- cpu_addr  in  ADDR_W  CPU address (AB[9:0]).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_done  out  1  one-cycle pulse at completion of a CPU access.
- cpu_rdata  out  DATA_W  last CPU read data; held until the next CPU read completes.
- cpu_err  out  1  sticky: a strobe arrived while an access was still pending.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address is issued.

## Operation
- CPU pending register holds pend, p_we, p_addr and p_wdata. cpu_strobe loads it and sets pend=1. pend clears in the cycle the CPU access is issued.
- If cpu_strobe arrives while pend=1:
  - Set cpu_err.
  - Overwrite the pending register with the new request.
  - Reset wait_cnt.
- wait_cnt:
  - Reset to 0 on strobe.
  - Increment by 1 each cycle pend=1 and the CPU is not granted.
  - Saturate at STARVE_MAX.
- force = pend && (wait_cnt == STARVE_MAX). vid_ready = ~force && ~reset. vid_ready depends on registers only, with no combinational path from vid_req.
- Grant each cycle, in priority order: force → CPU; vid_req → video; pend → CPU; else idle.
- The grant decision uses only the registered pend. A CPU request is never issued in its own strobe cycle.
- Issue cycle N, video grant: ram_addr = vid_addr, ram_we = 0.
- Issue cycle N, CPU grant: ram_addr = p_addr; ram_we = p_we; ram_wdata = p_wdata.
- Idle cycle: ram_we = 0. ram_addr and ram_wdata hold their previous values.
- A 2-stage owner pipeline (NONE/VID/CPU_RD/CPU_WR) tracks each issued access.
  - Stage 1 (N+1): capture ram_rdata.
  - Stage 2 (N+2): VID → vid_valid=1, vid_rdata=captured data. CPU_RD → cpu_done=1, cpu_rdata=captured data. CPU_WR → cpu_done=1, cpu_rdata unchanged.
- Back-to-back issue is allowed every cycle, with any mix of owners.
- A CPU read issued in the cycle right after a CPU write to the same address returns the new data. The RAM is write-first; no bypass logic is required.

## Timing
- Reset values: vid_ready=0, vid_valid=0, vid_rdata=0, cpu_done=0, cpu_rdata=0, cpu_err=0, ram_we=0, ram_addr=0, ram_wdata=0. Internally pend=0, wait_cnt=0, both pipeline stages NONE.
- Reset asserted mid-operation:
  - Discard in-flight accesses: no vid_valid or cpu_done pulse is produced for them.
  - Drop the pending CPU request.
  - ram_we goes low on the first reset edge.
- Video latency: accept at N → vid_valid at N+2. Sustained throughput is 1 read/clk while vid_ready=1.
- CPU latency with the arbiter idle: strobe at S → issue at S+1 → cpu_done at S+3.
- CPU worst case under continuous vid_req: issue at S+1+STARVE_MAX, cpu_done at S+3+STARVE_MAX (11 cycles at default). This is always below 33.
- vid_ready is low for exactly one cycle per forced grant.
- Simultaneous cpu_strobe and vid_req: video is granted, and the CPU request becomes pending.

## Test plan
- Idle arbiter, CPU write 0x5A to 0x123 (strobe S), then read 0x123 (strobe S+5) → ram_we=1 only at S+1; cpu_done at S+3 and S+8; cpu_rdata=0x5A at S+8.
- Video stream addresses 0..15, no CPU traffic → vid_ready stays 1; vid_valid on 16 consecutive cycles from 2 cycles after the first accept; data in order.
- Continuous vid_req plus CPU read strobe at S → vid_ready=0 only at S+9; CPU issue at S+9; cpu_done at S+11; no video data lost or reordered.
- cpu_strobe in the same cycle as vid_req with video idle afterward → video issued at S, CPU at S+1, cpu_done at S+3.
- Second cpu_strobe at S+1 while the first is still pending under video load → cpu_err=1 and stays 1; only the second access completes, with exactly one cpu_done.
- Assert reset for 1 cycle at S+2 after a CPU read strobe at S → no cpu_done; all outputs at reset values the next cycle; normal operation afterwards.
